// File: rtl/completion_arbiter.sv
// Shares the ROB completion ports among the FU result buses. Each FU has a one-entry holding register, and a round-robin scheduler drains those registers.
// Define ARB_PERF_EN to add the perf_grant_count and perf_conflict_count outputs.
module completion_arbiter #(
    parameter int NUM_FU        = 5,
    parameter int NUM_PORTS     = 3,
    parameter int ROB_SIZE_LOG2 = 6,
    parameter int NUM_TAGS_LOG2 = 6,
    parameter int REG_SIZE      = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     hold_in,
    input  logic [NUM_FU-1:0]        fu_valid,
    input  logic [ROB_SIZE_LOG2-1:0] fu_rob_index    [NUM_FU],
    input  logic [NUM_TAGS_LOG2-1:0] fu_tag          [NUM_FU],
    input  logic [REG_SIZE-1:0]      fu_data         [NUM_FU],
    output logic [NUM_FU-1:0]        fu_ready,
    output logic [NUM_PORTS-1:0]     complete,
    output logic [ROB_SIZE_LOG2-1:0] rob_index       [NUM_PORTS],
    output logic [NUM_TAGS_LOG2-1:0] tag_rd_complete [NUM_PORTS],
    output logic [REG_SIZE-1:0]      data_rd         [NUM_PORTS]
`ifdef ARB_PERF_EN
    ,
    output logic [31:0]              perf_grant_count,
    output logic [31:0]              perf_conflict_count
`endif
);

    localparam int PTR_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
    localparam int CNT_W = $clog2(NUM_PORTS + 1);

    logic [NUM_FU-1:0]        held;
    logic [ROB_SIZE_LOG2-1:0] held_rob  [NUM_FU];
    logic [NUM_TAGS_LOG2-1:0] held_tag  [NUM_FU];
    logic [REG_SIZE-1:0]      held_data [NUM_FU];

    logic [PTR_W-1:0]         rr_ptr;
    logic [PTR_W-1:0]         rr_ptr_next;
    logic [PTR_W-1:0]         scan_idx;
    logic [PTR_W-1:0]         last_idx;
    logic [CNT_W-1:0]         grant_cnt;
    logic [NUM_FU-1:0]        granted;
    logic [NUM_PORTS-1:0]     port_vld;
    logic [PTR_W-1:0]         port_sel  [NUM_PORTS];
    logic                     grant_en;

    assign grant_en = ~hold_in & ~flush;

    // Walk the FUs from rr_ptr and hand the first NUM_PORTS held entries to ports in scan order.
    always_comb begin
        granted   = '0;
        port_vld  = '0;
        grant_cnt = '0;
        scan_idx  = '0;
        last_idx  = rr_ptr;
        for (int p = 0; p < NUM_PORTS; p++) begin
            port_sel[p] = '0;
        end
        for (int k = 0; k < NUM_FU; k++) begin
            scan_idx = PTR_W'((int'(rr_ptr) + k) % NUM_FU);
            if (grant_en && held[scan_idx] && (int'(grant_cnt) < NUM_PORTS)) begin
                granted[scan_idx]   = 1'b1;
                port_vld[grant_cnt] = 1'b1;
                port_sel[grant_cnt] = scan_idx;
                last_idx            = scan_idx;
                grant_cnt           = grant_cnt + CNT_W'(1);
            end
        end
        rr_ptr_next = (|granted) ? PTR_W'((int'(last_idx) + 1) % NUM_FU) : rr_ptr;
    end

    always_comb begin
        complete = port_vld;
        for (int p = 0; p < NUM_PORTS; p++) begin
            rob_index[p]       = port_vld[p] ? held_rob[port_sel[p]]  : '0;
            tag_rd_complete[p] = port_vld[p] ? held_tag[port_sel[p]]  : '0;
            data_rd[p]         = port_vld[p] ? held_data[port_sel[p]] : '0;
        end
    end

    // A slot being drained this cycle can take a new result in the same cycle.
    assign fu_ready = ~held | granted;

    always_ff @(posedge clk) begin
        if (!rst) begin
            held   <= '0;
            rr_ptr <= '0;
        end else if (flush) begin
            held <= '0;
        end else begin
            rr_ptr <= rr_ptr_next;
            for (int i = 0; i < NUM_FU; i++) begin
                if (fu_valid[i] && fu_ready[i]) begin
                    held[i] <= 1'b1;
                end else if (granted[i]) begin
                    held[i] <= 1'b0;
                end
            end
        end
    end

    // Payload registers need no reset because the outputs are masked by held and granted.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_FU; i++) begin
            if (rst && !flush && fu_valid[i] && fu_ready[i]) begin
                held_rob[i]  <= fu_rob_index[i];
                held_tag[i]  <= fu_tag[i];
                held_data[i] <= fu_data[i];
            end
        end
    end

`ifdef ARB_PERF_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            perf_grant_count    <= '0;
            perf_conflict_count <= '0;
        end else begin
            perf_grant_count <= perf_grant_count + 32'($countones(granted));
            if (grant_en && ($countones(held) > NUM_PORTS)) begin
                perf_conflict_count <= perf_conflict_count + 32'd1;
            end
        end
    end
`endif

endmodule
